// File: rtl/sevenseg_scan_mux.sv
// Multiplexed digit scanner for common-anode 7-segment displays, with a double-buffered value and guard blanking.
// Optional leading-zero suppression: define SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_mux #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [3:0]            digit_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_n,
  output logic                  blank,
  output logic                  frame_tick
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW:0]   GUARD_LEN = (PW+1)'(BLANK_CYCLES);

  typedef enum logic {S_GUARD, S_ON} state_t;

  state_t               state, state_next;
  logic [PW-1:0]        prescaler, pre_next;
  logic [IW-1:0]        idx, idx_next;
  logic [4*DIGITS-1:0]  active_val, pending_val, act_val_next;
  logic [DIGITS-1:0]    active_dp, pending_dp, act_dp_next;
  logic                 pending_valid;
  logic                 boundary;
  logic [DIGITS-1:0]    show_mask;
  logic [DIGITS-1:0]    an_next;
  logic [3:0]           nib_next;
  logic                 dp_next;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0]        lead_top;
`endif

  always_comb begin
    boundary = (prescaler == PRE_LAST) && (idx == IDX_LAST);
    pre_next = (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
    idx_next = idx;
    if (prescaler == PRE_LAST)
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // A load on the boundary edge bypasses pending and wins over it.
    act_val_next = active_val;
    act_dp_next  = active_dp;
    if (boundary) begin
      if (load) begin
        act_val_next = value;
        act_dp_next  = dp_in;
      end else if (pending_valid) begin
        act_val_next = pending_val;
        act_dp_next  = pending_dp;
      end
    end

    state_next = state;
    case (state)
      S_GUARD: if ({1'b0, pre_next} >= GUARD_LEN) state_next = S_ON;
      S_ON:    if (pre_next == '0 && GUARD_LEN != '0) state_next = S_GUARD;
      default: state_next = S_GUARD;
    endcase

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    // Highest nonzero digit of the value about to be active; digit 0 always stays lit.
    lead_top = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (act_val_next[4*i +: 4] != 4'h0) lead_top = IW'(i);
    for (int unsigned i = 0; i < DIGITS; i++)
      show_mask[i] = (IW'(i) <= lead_top) || act_dp_next[i];
`else
    show_mask = '1;
`endif

    nib_next = '0;
    dp_next  = 1'b0;
    an_next  = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        nib_next = act_val_next[4*i +: 4];
        dp_next  = act_dp_next[i];
        if (state_next == S_ON && show_mask[i]) an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler     <= '0;
      idx           <= '0;
      state         <= S_GUARD;
      active_val    <= '0;
      active_dp     <= '0;
      pending_val   <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      digit_out     <= '0;
      dp_out        <= 1'b0;
      an_n          <= '1;
      blank         <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      prescaler  <= pre_next;
      idx        <= idx_next;
      state      <= state_next;
      active_val <= act_val_next;
      active_dp  <= act_dp_next;
      if (boundary) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_val   <= value;
        pending_dp    <= dp_in;
        pending_valid <= 1'b1;
      end
      digit_out  <= nib_next;
      dp_out     <= dp_next;
      an_n       <= an_next;
      blank      <= &an_next;
      frame_tick <= boundary;
    end
  end

endmodule
